// File: rtl/cp0_ctrl.sv
// CP0 status/cause/EPC block: mtc0/mfc0 access, interrupt and exception entry, eret return.
// Entry raises int_req in the same cycle so the pipeline flushes and redirects to the handler.
module cp0_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [4:0]  exc_code,
   input  logic [5:0]  hw_int,
   input  logic        eret,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        int_req
);

   localparam logic [4:0]  ADDR_SR    = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE = 5'd13;
   localparam logic [4:0]  ADDR_EPC   = 5'd14;
   localparam logic [4:0]  ADDR_PRID  = 5'd15;
   localparam logic [31:0] PRID_VAL   = 32'h0000_00C0;

   logic [5:0]  sr_im_q,     sr_im_d;
   logic        sr_exl_q,    sr_exl_d;
   logic        sr_ie_q,     sr_ie_d;
   logic        cause_bd_q,  cause_bd_d;
   logic [5:0]  cause_ip_q,  cause_ip_d;
   logic [4:0]  cause_exc_q, cause_exc_d;
   logic [31:0] epc_q,       epc_d;
   logic        irq_hit;
   logic        exc_hit;

   // EXL masks both sources so a handler is never re-entered
   always_comb begin
      irq_hit = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
      exc_hit = (exc_code != 5'd0) & ~sr_exl_q;
      int_req = irq_hit | exc_hit;
   end

   // Next state: entry beats eret, eret beats mtc0; IP tracks hw_int every cycle
   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_ip_d  = hw_int;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      if (int_req) begin
         sr_exl_d    = 1'b1;
         cause_bd_d  = bd_m;
         cause_exc_d = irq_hit ? 5'd0 : exc_code;
         epc_d       = bd_m ? (pc_m - 32'd4) : pc_m;
      end else begin
         if (we) begin
            case (addr)
               ADDR_SR: begin
                  sr_im_d  = wdata[15:10];
                  sr_exl_d = wdata[1];
                  sr_ie_d  = wdata[0];
               end
               ADDR_EPC: epc_d = wdata;
               default:  epc_d = epc_q;
            endcase
         end else begin
            epc_d = epc_q;
         end
         if (eret) begin
            sr_exl_d = 1'b0;
         end else begin
            sr_ie_d = sr_ie_d;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im_q     <= 6'd0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= 6'd0;
         cause_exc_q <= 5'd0;
         epc_q       <= 32'd0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

   // mfc0 read mux; unimplemented bits and registers read as zero
   always_comb begin
      case (addr)
         ADDR_SR:    rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
         ADDR_CAUSE: rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
         ADDR_EPC:   rdata = epc_q;
         ADDR_PRID:  rdata = PRID_VAL;
         default:    rdata = 32'd0;
      endcase
   end

   assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a register-word model.
module tb_cp0_ctrl;

   logic        clk = 1'b0;
   logic        reset, we, bd_m, eret;
   logic [4:0]  addr, exc_code;
   logic [5:0]  hw_int;
   logic [31:0] wdata, pc_m;
   logic [31:0] rdata, epc_out;
   logic        int_req;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_sr, m_cause, m_epc;
   logic [31:0] v;

   cp0_ctrl dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
      .pc_m(pc_m), .bd_m(bd_m), .exc_code(exc_code), .hw_int(hw_int),
      .eret(eret), .rdata(rdata), .epc_out(epc_out), .int_req(int_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model works on whole architectural register words
   function automatic logic m_irq(input logic [31:0] sr, input logic [5:0] hw);
      return ((hw & sr[15:10]) != 6'd0) && sr[0] && !sr[1];
   endfunction

   function automatic logic m_req(input logic [31:0] sr, input logic [5:0] hw, input logic [4:0] ec);
      return m_irq(sr, hw) || ((ec != 5'd0) && !sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h0000_00C0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] next_sr(input logic [31:0] sr);
      logic [31:0] s;
      s = (we && addr == 5'd12) ? (wdata & 32'h0000_FC03) : sr;
      if (eret) s = s & ~32'h2;
      return s;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_sr    <= 32'd0;
         m_cause <= 32'd0;
         m_epc   <= 32'd0;
      end else if (m_req(m_sr, hw_int, exc_code)) begin
         m_sr    <= m_sr | 32'h2;
         m_cause <= ({31'd0, bd_m} << 31) | ({26'd0, hw_int} << 10) |
                    (m_irq(m_sr, hw_int) ? 32'd0 : ({27'd0, exc_code} << 2));
         m_epc   <= pc_m - (bd_m ? 32'd4 : 32'd0);
      end else begin
         m_sr    <= next_sr(m_sr);
         m_cause <= (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
         m_epc   <= (we && addr == 5'd14) ? wdata : m_epc;
      end
   end

   // Compare process: outputs against the model, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rdata_model", rdata, m_read(addr));
         chk("epc_out_model", epc_out, m_epc);
         chk("int_req_model", {31'd0, int_req}, {31'd0, m_req(m_sr, hw_int, exc_code)});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      we = 1'b0; eret = 1'b0; exc_code = 5'd0; hw_int = 6'd0; bd_m = 1'b0;
      pc_m = 32'h0000_3000; wdata = 32'd0; addr = 5'd0;
   endtask

   task automatic peek(input logic [4:0] a, output logic [31:0] val);
      addr = a;
      #1;
      val = rdata;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      chk_en = 1'b1;
      peek(5'd12, v); chk("reset_sr", v, 32'd0);
      peek(5'd13, v); chk("reset_cause", v, 32'd0);
      peek(5'd14, v); chk("reset_epc", v, 32'd0);
      chk("reset_epc_out", epc_out, 32'd0);
      chk("reset_int_req", {31'd0, int_req}, 32'd0);

      // Interrupt entry
      reset = 1'b0;
      we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
      tick();
      we = 1'b0; hw_int = 6'b000100; pc_m = 32'h0000_3010; bd_m = 1'b0;
      peek(5'd12, v); chk("sr_written", v, 32'h0000_FC01);
      chk("irq_same_cycle", {31'd0, int_req}, 32'd1);
      tick();
      hw_int = 6'd0;
      peek(5'd14, v); chk("irq_epc", v, 32'h0000_3010);
      peek(5'd13, v); chk("irq_cause", v, 32'h0000_1000);
      peek(5'd12, v); chk("irq_sr_exl", v, 32'h0000_FC03);

      // No nesting while EXL, then eret re-opens interrupts
      hw_int = 6'h3F; exc_code = 5'd4;
      #1 chk("exl_blocks", {31'd0, int_req}, 32'd0);
      tick();
      eret = 1'b1;
      #1 chk("exl_blocks_eret_cycle", {31'd0, int_req}, 32'd0);
      tick();
      eret = 1'b0; exc_code = 5'd12; pc_m = 32'h0000_3040;
      #1 chk("irq_after_eret", {31'd0, int_req}, 32'd1);
      tick();
      hw_int = 6'd0; exc_code = 5'd0;
      peek(5'd13, v); chk("irq_beats_exc", v, 32'h0000_FC00);
      peek(5'd14, v); chk("irq_beats_exc_epc", v, 32'h0000_3040);

      // eret overrides EXL in a coincident SR write
      eret = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03;
      tick();
      eret = 1'b0; we = 1'b0;
      peek(5'd12, v); chk("eret_vs_mtc0", v, 32'h0000_FC01);

      // Entry drops a coincident EPC write
      we = 1'b1; addr = 5'd14; wdata = 32'h0000_4000; hw_int = 6'b000001; pc_m = 32'h0000_3050;
      #1 chk("req_with_mtc0", {31'd0, int_req}, 32'd1);
      tick();
      we = 1'b0; hw_int = 6'd0;
      peek(5'd14, v); chk("mtc0_dropped", v, 32'h0000_3050);

      // Exception in a delay slot
      eret = 1'b1;
      tick();
      eret = 1'b0; exc_code = 5'd10; pc_m = 32'h0000_3020; bd_m = 1'b1;
      #1 chk("exc_req", {31'd0, int_req}, 32'd1);
      tick();
      exc_code = 5'd0; bd_m = 1'b0;
      peek(5'd14, v); chk("exc_epc_bd", v, 32'h0000_301C);
      peek(5'd13, v); chk("exc_cause", v, 32'h8000_0028);
      peek(5'd12, v); chk("exc_sr_exl", v, 32'h0000_FC03);

      // EPC subtraction wraps
      eret = 1'b1;
      tick();
      eret = 1'b0; exc_code = 5'd1; pc_m = 32'd0; bd_m = 1'b1;
      tick();
      exc_code = 5'd0; bd_m = 1'b0;
      peek(5'd14, v); chk("epc_wrap", v, 32'hFFFF_FFFC);

      // Reset mid-handler beats a write
      reset = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF; hw_int = 6'h3F;
      tick();
      reset = 1'b0; we = 1'b0; hw_int = 6'd0;
      peek(5'd12, v); chk("rst_sr", v, 32'd0);
      peek(5'd13, v); chk("rst_cause", v, 32'd0);
      peek(5'd15, v); chk("prid", v, 32'h0000_00C0);
      chk("rst_epc_out", epc_out, 32'd0);

      // EPC write is not forwarded
      we = 1'b1; addr = 5'd14; wdata = 32'h1234_5678;
      #1 chk("no_forward", epc_out, 32'd0);
      tick();
      we = 1'b0; addr = 5'd3;
      chk("epc_next_cycle", epc_out, 32'h1234_5678);
      #1 chk("unmapped_addr", rdata, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         reset = ($urandom_range(63) == 0);
         we    = ($urandom_range(3) == 0);
         r     = $urandom_range(7);
         case (r)
            0, 1:    addr = 5'd12;
            2:       addr = 5'd13;
            3, 4:    addr = 5'd14;
            5:       addr = 5'd15;
            default: addr = 5'($urandom);
         endcase
         wdata    = $urandom;
         hw_int   = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
         exc_code = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
         eret     = ($urandom_range(5) == 0);
         pc_m     = $urandom & 32'hFFFF_FFFC;
         bd_m     = 1'($urandom_range(1));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have we, input, 1 bit: mtc0 write enable from the M stage.
REQ-004 SHALL have addr, input, 5 bits: CP0 register number for mtc0/mfc0.
REQ-005 SHALL have wdata, input, 32 bits: mtc0 write data.
REQ-006 SHALL have pc_m, input, 32 bits: PC of the M-stage instruction.
REQ-007 SHALL have bd_m, input, 1 bit: M-stage instruction sits in a branch delay slot.
REQ-008 SHALL have exc_code, input, 5 bits: exception code carried to M (0 = none).
REQ-009 SHALL have hw_int, input, 6 bits: external interrupt lines, sampled each cycle.
REQ-010 SHALL have eret, input, 1 bit: M-stage instruction is eret.
REQ-011 SHALL have rdata, output, 32 bits: mfc0 read data, combinational on addr.
REQ-012 SHALL have epc_out, output, 32 bits: current EPC register value.
REQ-013 SHALL have int_req, output, 1 bit: flush request to the pipeline registers and PC redirect to 0x0000_4180.

Function
REQ-014 SHALL implement SR (reg 12) with writable fields IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-015 SHALL implement Cause (reg 13) with fields BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits SHALL read 0; mtc0 SHALL NOT write Cause.
REQ-016 SHALL implement EPC (reg 14) as a 32-bit register writable by mtc0.
REQ-017 SHALL implement PRId (reg 15) as read-only constant 0x0000_00C0.
REQ-018 SHALL return 0 on rdata for any other addr.
REQ-019 SHALL compute irq_hit = |(hw_int & SR.IM) & SR.IE & !SR.EXL, combinationally.
REQ-020 SHALL compute exc_hit = (exc_code != 0) & !SR.EXL, combinationally.
REQ-021 SHALL drive int_req = irq_hit | exc_hit, combinationally, in the same cycle.
REQ-022 SHALL load Cause.IP <= hw_int on every clock edge not in reset, independent of all other events.
REQ-023 On an edge with int_req=1, SHALL set SR.EXL <= 1.
REQ-024 On an edge with int_req=1, SHALL set Cause.BD <= bd_m.
REQ-025 On an edge with int_req=1, SHALL set Cause.ExcCode <= 0 when irq_hit, else exc_code; interrupt takes priority over exception.
REQ-026 On an edge with int_req=1, SHALL set EPC <= bd_m ? pc_m-4 : pc_m; the subtraction SHALL be 32-bit and wrap modulo 2^32.
REQ-027 On an edge with int_req=0 and eret=1, SHALL clear SR.EXL <= 0.
REQ-028 On an edge with int_req=0 and we=1, SHALL write the register selected by addr (12 or 14); writes to any other addr SHALL be ignored.
REQ-029 SHALL apply priority int_req > eret > mtc0 when these coincide; a suppressed eret or mtc0 SHALL have no effect.
REQ-030 When eret and mtc0 to SR coincide without int_req, SHALL let eret's EXL clear override the written EXL bit, with the other SR fields taken from wdata.
REQ-031 SHALL NOT forward mtc0 wdata to epc_out or rdata in the same cycle; new values SHALL appear from the next cycle.
REQ-032 While SR.EXL=1, SHALL hold int_req=0 regardless of hw_int or exc_code (no nesting).

Reset
REQ-033 On reset=1 at an edge, SHALL clear SR, Cause and EPC to 0; reset SHALL override int_req, eret and we in the same cycle.
REQ-034 After reset, outputs SHALL be rdata = 0 for addr 12, 13 and 14, epc_out = 0, and int_req = 0 (IE=0, EXL=0, given exc_code=0).
REQ-035 Reset asserted mid-handler (EXL=1) SHALL return EXL to 0 at the next edge.

Verification
REQ-036 Reset, then mtc0 SR=0x0000_FC01 and pulse hw_int=6'b000100 with pc_m=0x3010 and bd_m=0 -> same-cycle int_req=1; next cycle EPC=0x3010, Cause=0x0000_1000, SR.EXL=1.
REQ-037 exc_code=5'd10 with pc_m=0x3020 and bd_m=1 -> int_req=1; EPC=0x301C, Cause.BD=1, ExcCode=10, EXL=1.
REQ-038 EXL=1 with hw_int=6'h3F and exc_code=4 -> int_req stays 0; eret clears EXL, and int_req rises the next cycle if hw_int is still masked-in.
REQ-039 hw_int and exc_code=12 in the same cycle -> ExcCode=0 (interrupt wins).
REQ-040 mtc0 EPC=0x0000_4000 together with int_req=1 -> EPC=pc_m, the write is dropped; eret plus mtc0 SR=0x0000_FC03 -> SR=0x0000_FC01.
REQ-041 Reset asserted with EXL=1 and we=1 -> SR, Cause and EPC all 0 next cycle; PRId reads 0x0000_00C0 throughout.
